ft601_fifo_slv: RTL and testbench

Synthesizable FT601 245-synchronous FIFO slave: the device end of the bus that the FPGA master pad ring drives. It answers WR_N/RD_N/OE_N from a master, reports buffer status on TXE_N/RXF_N, and splits the shared DATA/BE bus into input, output and output-enable signals. It backs each direction with a buffer toward a host-side user port, and serves loopback self-test and master bring-up inside the fabric without a physical FT601.

---
 rtl/pkg_ft601_ctrl_defines.sv | 22 ++
 rtl/ft601_slv_fifo.sv | 81 ++++++++
 rtl/ft601_fifo_slv.sv | 179 +++++++++++++++++
 tb/tb_ft601_fifo_slv.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkg_ft601_ctrl_defines.sv
// Shared definitions for the FT601 245-synchronous FIFO slave.
//   WIDTH_DATA / CNT_BE : bus data width and byte-enable lane count
//   ft601_slv_state_t   : slave bus FSM states
//   ft601_word_t        : one buffered bus word {data, be}
package pkg_ft601_ctrl_defines;

  localparam int unsigned WIDTH_DATA = 32;
  localparam int unsigned CNT_BE     = WIDTH_DATA / 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RD_TA = 2'd1,
    ST_RD    = 2'd2,
    ST_WR    = 2'd3
  } ft601_slv_state_t;

  typedef struct packed {
    logic [WIDTH_DATA-1:0] data;
    logic [CNT_BE-1:0]     be;
  } ft601_word_t;

endpackage

// File: rtl/ft601_slv_fifo.sv
// Synchronous first-word-fall-through buffer with registered head and flags.
//   clk_i, rst_i : clock, synchronous active-high reset
//   push_i/din_i : write request and payload (dropped when full unless popping)
//   pop_i        : read request (dropped when empty)
//   dout_o       : registered head word, valid whenever empty_o is low
//   count_o      : words held; full_o / empty_o registered from next count
module ft601_slv_fifo #(
  parameter int unsigned WIDTH = 36,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           din_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             full_q, empty_q;
  logic             push_ok, pop_ok;

  // A push at full is legal only when a pop frees the slot in the same cycle.
  always_comb begin
    pop_ok   = pop_i && !empty_q;
    push_ok  = push_i && (!full_q || pop_ok);
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    // Next head is the word being written when it lands at the new read slot.
    if (count_d == CW'(0)) begin
      head_d = head_q;
    end else if (push_ok && (rd_ptr_d == wr_ptr_q)) begin
      head_d = din_i;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  // Storage array: no reset, pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  // Pointers, count, head and flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      full_q   <= (count_d == CW'(DEPTH));
      empty_q  <= (count_d == CW'(0));
    end
  end

  assign dout_o  = head_q;
  assign count_o = count_q;
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/ft601_fifo_slv.sv
// FT601 245-synchronous FIFO slave: device end of the bus driven by an FPGA
// master. Optional flush pulse on SIWU_N enabled by macro FT601_SLV_SIWU_EN.
//   CLK, RESET                 : clock, synchronous active-high reset
//   DATA_I/BE_I, DATA_O/BE_O   : split shared bus, DATA_OE drives DATA_O/BE_O
//   TXE_N, RXF_N               : buffer status toward the master
//   WR_N, RD_N, OE_N, SIWU_N   : master strobes, active low
//   rx_wr_*, rx_full           : host push port toward the master (rx buffer)
//   tx_rd_*, tx_empty          : host pop port for master writes (tx buffer)
//   tx_siwu                    : one-cycle flush pulse
//   bus_err                    : sticky protocol error
module ft601_fifo_slv
  import pkg_ft601_ctrl_defines::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [WIDTH_DATA-1:0] DATA_I,
  output logic [WIDTH_DATA-1:0] DATA_O,
  output logic                  DATA_OE,
  input  logic [CNT_BE-1:0]     BE_I,
  output logic [CNT_BE-1:0]     BE_O,
  output logic                  TXE_N,
  output logic                  RXF_N,
  input  logic                  WR_N,
  input  logic                  RD_N,
  input  logic                  OE_N,
  input  logic                  SIWU_N,
  input  logic                  rx_wr_en,
  input  logic [WIDTH_DATA-1:0] rx_wr_data,
  input  logic [CNT_BE-1:0]     rx_wr_be,
  output logic                  rx_full,
  input  logic                  tx_rd_en,
  output logic [WIDTH_DATA-1:0] tx_rd_data,
  output logic [CNT_BE-1:0]     tx_rd_be,
  output logic                  tx_empty,
  output logic                  tx_siwu,
  output logic                  bus_err
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned WW = $bits(ft601_word_t);

  ft601_slv_state_t state_q, state_d;
  logic             data_oe_q, data_oe_d;
  logic             bus_err_q, bus_err_d;
  logic             rx_push, rx_pop, tx_push;
  logic             rx_full_w, rx_empty_w, tx_full_w, tx_empty_w;
  ft601_word_t      rx_din, rx_head, tx_din, tx_head;
  logic [CW-1:0]    rx_count, tx_count;
  logic             unused_cnt;

  // Bus FSM state and registered bus outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      data_oe_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_oe_q <= data_oe_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Next state, buffer strobes and error detection.
  always_comb begin
    state_d   = state_q;
    rx_pop    = 1'b0;
    tx_push   = 1'b0;
    bus_err_d = bus_err_q;
    case (state_q)
      ST_IDLE: begin
        if (!OE_N && !RXF_N) begin
          state_d = ST_RD_TA;
        end else if (!WR_N && OE_N) begin
          // The cycle that enters ST_WR already carries a valid word.
          state_d = ST_WR;
          tx_push = 1'b1;
        end
      end
      ST_RD_TA: begin
        state_d = ST_RD;
      end
      ST_RD: begin
        rx_pop = !RD_N && !RXF_N;
        if (OE_N) begin
          state_d = ST_IDLE;
        end
      end
      ST_WR: begin
        tx_push = !WR_N && OE_N;
        if (WR_N) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Drive the bus only while the master is reading.
    data_oe_d = (state_d == ST_RD);
    if ((!WR_N && !OE_N) || (!RD_N && (state_q != ST_RD)) || (!WR_N && TXE_N)) begin
      bus_err_d = 1'b1;
    end
  end

  assign rx_push = rx_wr_en && !rx_full_w;
  assign rx_din  = {rx_wr_data, rx_wr_be};
  assign tx_din  = {DATA_I, BE_I};

  // Host -> master buffer.
  ft601_slv_fifo #(
    .WIDTH (WW),
    .DEPTH (DEPTH)
  ) u_rx_fifo (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .push_i  (rx_push),
    .din_i   (rx_din),
    .pop_i   (rx_pop),
    .dout_o  (rx_head),
    .count_o (rx_count),
    .full_o  (rx_full_w),
    .empty_o (rx_empty_w)
  );

  // Master -> host buffer; a host pop at full makes room for a same-cycle write.
  ft601_slv_fifo #(
    .WIDTH (WW),
    .DEPTH (DEPTH)
  ) u_tx_fifo (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .push_i  (tx_push),
    .din_i   (tx_din),
    .pop_i   (tx_rd_en),
    .dout_o  (tx_head),
    .count_o (tx_count),
    .full_o  (tx_full_w),
    .empty_o (tx_empty_w)
  );

  assign unused_cnt = ^{rx_count, tx_count};

`ifdef FT601_SLV_SIWU_EN
  logic siwu_n_prev_q;
  logic tx_siwu_q;

  // One pulse per SIWU_N falling edge, only when there is something to flush.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      siwu_n_prev_q <= 1'b1;
      tx_siwu_q     <= 1'b0;
    end else begin
      siwu_n_prev_q <= SIWU_N;
      tx_siwu_q     <= !SIWU_N && siwu_n_prev_q && (!tx_empty_w || tx_push);
    end
  end

  assign tx_siwu = tx_siwu_q;
`else
  logic unused_siwu;
  assign unused_siwu = SIWU_N;
  assign tx_siwu     = 1'b0;
`endif

  assign DATA_O     = rx_head.data;
  assign BE_O       = rx_head.be;
  assign DATA_OE    = data_oe_q;
  assign RXF_N      = rx_empty_w;
  assign TXE_N      = tx_full_w;
  assign rx_full    = rx_full_w;
  assign tx_rd_data = tx_head.data;
  assign tx_rd_be   = tx_head.be;
  assign tx_empty   = tx_empty_w;
  assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_ft601_fifo_slv.sv
// Scoreboard bench for ft601_fifo_slv: stimulus queues expected words, a
// negedge monitor pops and compares whenever the DUT presents a transfer.
module tb_ft601_fifo_slv;
  import pkg_ft601_ctrl_defines::*;

  localparam int unsigned DEPTH = 16;

  logic                  CLK = 1'b0;
  logic                  RESET;
  logic [WIDTH_DATA-1:0] DATA_I, DATA_O, rx_wr_data, tx_rd_data;
  logic [CNT_BE-1:0]     BE_I, BE_O, rx_wr_be, tx_rd_be;
  logic                  DATA_OE, TXE_N, RXF_N;
  logic                  WR_N, RD_N, OE_N, SIWU_N;
  logic                  rx_wr_en, rx_full, tx_rd_en, tx_empty, tx_siwu, bus_err;

  int checks   = 0;
  int failures = 0;

  ft601_word_t rx_q[$];
  ft601_word_t tx_q[$];
  ft601_word_t mon_rx_e, mon_tx_e;

  ft601_fifo_slv #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET(RESET),
    .DATA_I(DATA_I), .DATA_O(DATA_O), .DATA_OE(DATA_OE),
    .BE_I(BE_I), .BE_O(BE_O),
    .TXE_N(TXE_N), .RXF_N(RXF_N),
    .WR_N(WR_N), .RD_N(RD_N), .OE_N(OE_N), .SIWU_N(SIWU_N),
    .rx_wr_en(rx_wr_en), .rx_wr_data(rx_wr_data), .rx_wr_be(rx_wr_be), .rx_full(rx_full),
    .tx_rd_en(tx_rd_en), .tx_rd_data(tx_rd_data), .tx_rd_be(tx_rd_be), .tx_empty(tx_empty),
    .tx_siwu(tx_siwu), .bus_err(bus_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a transfer completes at the next rising edge when these hold now.
  always @(negedge CLK) begin
    if (!RESET) begin
      if (DATA_OE && !RD_N && !RXF_N) begin
        if (rx_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL rx_unexpected_pop: got 0x%0h expected no word", DATA_O);
        end else begin
          mon_rx_e = rx_q.pop_front();
          chk("rx_word", {28'd0, DATA_O, BE_O}, {28'd0, mon_rx_e.data, mon_rx_e.be});
        end
      end
      if (tx_rd_en && !tx_empty) begin
        if (tx_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL tx_unexpected_pop: got 0x%0h expected no word", tx_rd_data);
        end else begin
          mon_tx_e = tx_q.pop_front();
          chk("tx_word", {28'd0, tx_rd_data, tx_rd_be}, {28'd0, mon_tx_e.data, mon_tx_e.be});
        end
      end
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    WR_N = 1'b1; RD_N = 1'b1; OE_N = 1'b1; SIWU_N = 1'b1;
    rx_wr_en = 1'b0; tx_rd_en = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RESET = 1'b1;
    cyc(); cyc();
    RESET = 1'b0;
    rx_q.delete();
    tx_q.delete();
    cyc();
  endtask

  task automatic host_push(input logic [31:0] d, input logic [3:0] be);
    rx_wr_en = 1'b1; rx_wr_data = d; rx_wr_be = be;
    rx_q.push_back({d, be});
    cyc();
    rx_wr_en = 1'b0;
  endtask

  task automatic master_write(input logic [31:0] d, input logic [3:0] be);
    WR_N = 1'b0; OE_N = 1'b1; DATA_I = d; BE_I = be;
    tx_q.push_back({d, be});
    cyc();
  endtask

  task automatic drain_tx(input string name);
    for (int k = 0; k < 200 && tx_q.size() != 0; k++) begin
      tx_rd_en = 1'($urandom_range(0, 1));
      cyc();
    end
    tx_rd_en = 1'b0;
    cyc();
    chk(name, 64'(tx_q.size()), 64'd0);
    chk("tx_empty_after_drain", 64'(tx_empty), 64'd1);
    chk("txe_n_after_drain", 64'(TXE_N), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n_rx, n_tx, sent_rx, sent_tx, k;
    logic [31:0] d;
    DATA_I = '0; BE_I = '0; rx_wr_data = '0; rx_wr_be = '0;
    do_reset();

    // Reset / idle state
    chk("rst_rxf_n", 64'(RXF_N), 64'd1);
    chk("rst_txe_n", 64'(TXE_N), 64'd0);
    chk("rst_data_oe", 64'(DATA_OE), 64'd0);
    chk("rst_tx_empty", 64'(tx_empty), 64'd1);
    chk("rst_rx_full", 64'(rx_full), 64'd0);
    chk("rst_bus_err", 64'(bus_err), 64'd0);
    chk("rst_tx_siwu", 64'(tx_siwu), 64'd0);
    chk("rst_data_o", {28'd0, DATA_O, BE_O}, 64'd0);

    // Host pushes four words, master reads them back
    for (int i = 0; i < 4; i++) host_push(32'h11111111 * 32'(i + 1), 4'hF);
    cyc();
    chk("rxf_n_after_push", 64'(RXF_N), 64'd0);
    OE_N = 1'b0;
    cyc();
    chk("data_oe_turnaround", 64'(DATA_OE), 64'd0);
    cyc();
    chk("data_oe_read", 64'(DATA_OE), 64'd1);
    RD_N = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    chk("rxf_n_after_4_pops", 64'(RXF_N), 64'd1);
    chk("rx_left_after_read", 64'(rx_q.size()), 64'd0);
    RD_N = 1'b1; OE_N = 1'b1;
    chk("data_oe_before_release", 64'(DATA_OE), 64'd1);
    cyc();
    chk("data_oe_after_release", 64'(DATA_OE), 64'd0);
    chk("bus_err_clean_read", 64'(bus_err), 64'd0);

    // Fill tx with DEPTH words, overflow write, then drain
    for (int i = 0; i < DEPTH; i++) master_write(32'(i), 4'($urandom_range(0, 15)));
    chk("txe_n_full", 64'(TXE_N), 64'd1);
    chk("bus_err_before_overflow", 64'(bus_err), 64'd0);
    DATA_I = 32'hBAD0BAD0; BE_I = 4'hF;
    cyc();
    WR_N = 1'b1;
    cyc();
    chk("bus_err_overflow", 64'(bus_err), 64'd1);
    drain_tx("tx_left_after_overflow");

    // Full tx with same-cycle host pop and master write
    do_reset();
    for (int i = 0; i < DEPTH; i++) master_write(32'h100 + 32'(i), 4'hF);
    tx_rd_en = 1'b1;
    master_write(32'hCAFE0001, 4'h5);
    tx_rd_en = 1'b0; WR_N = 1'b1;
    cyc();
    chk("txe_n_stays_full", 64'(TXE_N), 64'd1);
    chk("tx_q_size_full", 64'(tx_q.size()), 64'(DEPTH));
    drain_tx("tx_left_after_full_swap");

    // Write with OE_N low is an error and stores nothing
    do_reset();
    WR_N = 1'b0; OE_N = 1'b0; DATA_I = 32'h12345678;
    cyc();
    idle_inputs();
    cyc();
    chk("bus_err_wr_oe", 64'(bus_err), 64'd1);
    chk("tx_empty_wr_oe", 64'(tx_empty), 64'd1);

    // RD_N low outside a read is an error
    do_reset();
    RD_N = 1'b0;
    cyc();
    RD_N = 1'b1;
    cyc();
    chk("bus_err_rd_idle", 64'(bus_err), 64'd1);

    // Flush request alongside a write
    do_reset();
    SIWU_N = 1'b0;
    master_write(32'hDEADBEEF, 4'hF);
`ifdef FT601_SLV_SIWU_EN
    chk("tx_siwu_pulse", 64'(tx_siwu), 64'd1);
`else
    chk("tx_siwu_disabled", 64'(tx_siwu), 64'd0);
`endif
    WR_N = 1'b1;
    cyc();
    chk("tx_siwu_held_low", 64'(tx_siwu), 64'd0);
    SIWU_N = 1'b1;
    cyc();
    chk("tx_siwu_after", 64'(tx_siwu), 64'd0);
    drain_tx("tx_left_after_siwu");

    // Reset in the middle of an 8-word read
    do_reset();
    for (int i = 0; i < 8; i++) host_push($urandom, 4'($urandom_range(0, 15)));
    cyc();
    OE_N = 1'b0;
    cyc(); cyc();
    RD_N = 1'b0;
    cyc(); cyc(); cyc();
    RD_N = 1'b1;
    chk("rx_q_mid_read", 64'(rx_q.size()), 64'd5);
    RESET = 1'b1;
    cyc();
    chk("rst_mid_data_oe", 64'(DATA_OE), 64'd0);
    chk("rst_mid_rxf_n", 64'(RXF_N), 64'd1);
    RESET = 1'b0; OE_N = 1'b1;
    rx_q.delete();
    cyc();
    chk("rst_mid_rxf_n_hold", 64'(RXF_N), 64'd1);

    // Randomised concurrent traffic in both directions
    do_reset();
    for (int r = 0; r < 8; r++) begin
      n_rx = $urandom_range(1, DEPTH);
      n_tx = $urandom_range(1, DEPTH);
      sent_rx = 0; sent_tx = 0;
      while (sent_rx < n_rx || sent_tx < n_tx) begin
        rx_wr_en = 1'b0;
        WR_N = 1'b1;
        if (sent_rx < n_rx && $urandom_range(0, 3) != 0) begin
          d = $urandom;
          rx_wr_en = 1'b1; rx_wr_data = d; rx_wr_be = 4'($urandom_range(0, 15));
          rx_q.push_back({d, rx_wr_be});
          sent_rx++;
        end
        if (sent_tx < n_tx && $urandom_range(0, 3) != 0) begin
          d = $urandom;
          WR_N = 1'b0; DATA_I = d; BE_I = 4'($urandom_range(0, 15));
          tx_q.push_back({d, BE_I});
          sent_tx++;
        end
        cyc();
      end
      rx_wr_en = 1'b0; WR_N = 1'b1;
      cyc();
      chk("rnd_rxf_n", 64'(RXF_N), 64'd0);
      chk("rnd_rx_full", 64'(rx_full), 64'(n_rx == DEPTH));
      chk("rnd_txe_n", 64'(TXE_N), 64'(n_tx == DEPTH));
      chk("rnd_tx_empty", 64'(tx_empty), 64'd0);
      OE_N = 1'b0;
      cyc(); cyc();
      k = 0;
      while ((rx_q.size() != 0 || tx_q.size() != 0) && k < 300) begin
        RD_N = ($urandom_range(0, 2) == 0);
        tx_rd_en = 1'($urandom_range(0, 1));
        cyc();
        k++;
      end
      RD_N = 1'b1; tx_rd_en = 1'b0; OE_N = 1'b1;
      cyc();
      chk("rnd_rx_drained", 64'(rx_q.size()), 64'd0);
      chk("rnd_tx_drained", 64'(tx_q.size()), 64'd0);
      chk("rnd_rxf_n_end", 64'(RXF_N), 64'd1);
      chk("rnd_tx_empty_end", 64'(tx_empty), 64'd1);
      chk("rnd_data_oe_end", 64'(DATA_OE), 64'd0);
      chk("rnd_bus_err", 64'(bus_err), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
